// File: rtl/tick_gen.sv
// tick_gen: programmable tick divider with per-second strobe, toggles and a
// safely-applied runtime divisor (pending value takes effect at wrap or clr).
module tick_gen #(
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned DIV_RST   = 1_000_000,
    parameter int unsigned SEC_TICKS = 100,
    parameter int unsigned SEC_W     = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_in,
    output logic             tick_pulse,
    output logic             tick_toggle,
    output logic             sec_pulse,
    output logic             sec_toggle,
    output logic [SEC_W-1:0] tick_idx,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_err
);
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, pend_q, pend_d;
    logic [SEC_W-1:0] idx_q, idx_d;
    logic             tp_q, tt_q, sp_q, st_q, err_q;
    logic             wrap, tick, sec_last, wr_ok;
    always_comb begin
        wrap     = en && (cnt_q == div_q - CNT_W'(1));
        tick     = wrap && !clr;
        sec_last = idx_q == SEC_W'(SEC_TICKS - 1);
        wr_ok    = div_wr && (div_in != '0);
        // a fresh valid write is visible to the same wrap/clr edge
        pend_d   = wr_ok ? div_in : pend_q;
        div_d    = (clr || wrap) ? pend_d : div_q;
        cnt_d    = (clr || wrap) ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
        idx_d    = clr ? '0 : tick ? (sec_last ? '0 : idx_q + SEC_W'(1)) : idx_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            div_q  <= CNT_W'(DIV_RST);
            pend_q <= CNT_W'(DIV_RST);
            tp_q   <= 1'b0;
            tt_q   <= 1'b0;
            sp_q   <= 1'b0;
            st_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            div_q  <= div_d;
            pend_q <= pend_d;
            tp_q   <= tick;
            tt_q   <= tt_q ^ tick;
            sp_q   <= tick && sec_last;
            st_q   <= st_q ^ (tick && sec_last);
            err_q  <= div_wr && (div_in == '0);
        end
    end
    assign tick_pulse  = tp_q;
    assign tick_toggle = tt_q;
    assign sec_pulse   = sp_q;
    assign sec_toggle  = st_q;
    assign tick_idx    = idx_q;
    assign div_cur     = div_q;
    assign div_err     = err_q;
endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 SHALL provide parameter CNT_W, default 20: divider counter width in bits.
REQ-002 SHALL provide parameter DIV_RST, default 1_000_000: divisor loaded at reset (10 ms at 100 MHz); legal range 1..2^CNT_W-1.
REQ-003 SHALL provide parameter SEC_TICKS, default 100: ticks per second-strobe; legal range 1..65535.
REQ-004 SHALL provide parameter SEC_W, default 7: sub-second tick counter width, at least ceil(log2(SEC_TICKS)).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous reset, active-low.
REQ-007 SHALL have port en  input  1  count enable; 0 freezes all counters and toggles.
REQ-008 SHALL have port clr  input  1  synchronous restart of the divider and sub-second counter, without touching toggles or divisor.
REQ-009 SHALL have port div_wr  input  1  one-cycle request to load div_in.
REQ-010 SHALL have port div_in  input  CNT_W  new divisor value.
REQ-011 SHALL have port tick_pulse  output  1  one-cycle strobe every div_cur enabled cycles.
REQ-012 SHALL have port tick_toggle  output  1  inverts on every tick_pulse.
REQ-013 SHALL have port sec_pulse  output  1  one-cycle strobe on every SEC_TICKS-th tick.
REQ-014 SHALL have port sec_toggle  output  1  inverts on every sec_pulse.
REQ-015 SHALL have port tick_idx  output  SEC_W  ticks elapsed in the current second, 0..SEC_TICKS-1.
REQ-016 SHALL have port div_cur  output  CNT_W  divisor currently in effect.
REQ-017 SHALL have port div_err  output  1  one-cycle flag on a rejected divisor write.

Function
REQ-018 The divider count SHALL run 0..div_cur-1, advance only on cycles with en=1, and wrap to 0 on the enabled cycle where count==div_cur-1 (the wrap cycle).
REQ-019 All outputs SHALL be registered: tick_pulse high for exactly the cycle after a wrap cycle, low otherwise.
REQ-020 tick_toggle SHALL invert on the same edge that raises tick_pulse.
REQ-021 tick_idx SHALL increment on each wrap, wrapping SEC_TICKS-1 -> 0; on that wrap sec_pulse SHALL be high for the same cycle as tick_pulse, and sec_toggle SHALL invert on that edge.
REQ-022 With div_cur=1, every enabled cycle SHALL be a wrap cycle, so tick_pulse stays high while en=1.
REQ-023 en=0 SHALL hold count, tick_idx and both toggles, and drive tick_pulse, sec_pulse low on the following cycle; on resuming, counting continues from the held value.
REQ-024 div_wr with div_in in 1..2^CNT_W-1 SHALL latch div_in into a pending register; the pending value SHALL be copied to div_cur at the next wrap cycle or clr, whichever comes first.
REQ-025 div_wr with div_in=0 SHALL be ignored (pending register unchanged) and raise div_err for exactly one cycle.
REQ-026 A later div_wr before application SHALL overwrite the pending value; only the last valid value takes effect.
REQ-027 clr=1 SHALL set count and tick_idx to 0 and suppress tick_pulse and sec_pulse next cycle, regardless of en; toggles SHALL hold.
REQ-028 clr coincident with a wrap cycle SHALL win: no tick_pulse, no toggle change.
REQ-029 clr coincident with a valid div_wr SHALL apply div_in directly to div_cur on that edge.
REQ-030 A valid div_wr coincident with a wrap cycle SHALL take effect at that wrap; the new period starts immediately.

Reset
REQ-031 reset=0 at a rising edge SHALL set count=0, tick_idx=0, tick_pulse=0, tick_toggle=0, sec_pulse=0, sec_toggle=0, div_err=0, and div_cur and pending to DIV_RST, overriding all other inputs.
REQ-032 Reset mid-period SHALL discard the partial count and any pending divisor; the first tick after release SHALL follow DIV_RST enabled cycles.

Verification (bench parameters CNT_W=4, DIV_RST=5, SEC_TICKS=3, SEC_W=2)
REQ-033 Release reset, en=1 held -> tick_pulse high at cycles 6, 11, 16 after release; tick_toggle reads 1, 0, 1; sec_pulse high only at cycle 16; tick_idx 1, 2, 0.
REQ-034 en=0 for 4 cycles mid-period -> every subsequent tick delayed by exactly 4 cycles; toggles unchanged during the pause.
REQ-035 div_wr with div_in=2 at count 1 -> current period still 5; following ticks 2 cycles apart; div_cur=2 from that wrap on.
REQ-036 div_wr with div_in=0 -> div_err high for 1 cycle; div_cur and tick spacing unchanged.
REQ-037 clr on a wrap cycle -> no tick_pulse, tick_toggle unchanged, next tick 5 enabled cycles later, tick_idx=0.
REQ-038 reset=0 for 1 cycle with a pending divisor of 3 -> all outputs zero, div_cur=5, first tick 5 enabled cycles after release.
